// File: rtl/wb_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_master_if
// Brief    : Wishbone B3 master/slave signal bundle used by wb_burst_master.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_burst_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_master
// Brief    : Wishbone B3 initiator turning command/write streams into classic
//            and incrementing-burst cycles, with error and no-ack watchdog
//            termination.
// Revision : 1.0 - initial release
// ============================================================================
module wb_burst_master #(
  parameter int MAX_BURST = 16,
  parameter int LW        = $clog2(MAX_BURST),
  parameter int TIMEOUT   = 1023
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [31:0]   cmd_adr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_sel,
  output logic          rd_valid,
  output logic [31:0]   rd_data,
  output logic          rd_last,
  output logic          done,
  output logic          err,
  wb_burst_master_if.master wb
);

  localparam int             WDW      = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);
  localparam logic [2:0]     CTI_INC  = 3'b010;
  localparam logic [2:0]     CTI_END  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WFILL = 2'd1,
    BUS   = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [31:0]    adr;
  logic [31:0]    dat;
  logic [3:0]     sel;
  logic           we;
  logic           cyc;
  logic           stb;
  logic [2:0]     cti;
  logic [LW-1:0]  remaining;
  logic [WDW-1:0] wdog;

  logic           last_beat;
  logic           beat_ack;
  logic           abort;
  logic           unused_adr_bits;

  // Address is word aligned; the low bits are intentionally dropped.
  assign unused_adr_bits = ^cmd_adr[1:0];

  assign wb.wb_adr_o = adr;
  assign wb.wb_dat_o = dat;
  assign wb.wb_sel_o = sel;
  assign wb.wb_we_o  = we;
  assign wb.wb_cyc_o = cyc;
  assign wb.wb_stb_o = stb;
  assign wb.wb_cti_o = cti;
  assign wb.wb_bte_o = 2'b00;

  // State register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  // Next-state decode, beat qualification and client handshakes.
  always_comb begin
    last_beat = (remaining == '0);
    // Error wins over a simultaneous ack; the watchdog aborts the same way.
    abort     = (state == BUS) && stb &&
                (wb.wb_err_i || (!wb.wb_ack_i && (wdog == WD_LIMIT)));
    beat_ack  = (state == BUS) && stb && wb.wb_ack_i && !wb.wb_err_i;
    state_nx  = state;
    case (state)
      IDLE:  if (cmd_valid) state_nx = cmd_we ? WFILL : BUS;
      WFILL: if (wr_valid)  state_nx = BUS;
      BUS: begin
        if (abort)                   state_nx = IDLE;
        else if (beat_ack) begin
          if (last_beat)             state_nx = IDLE;
          else if (we && !wr_valid)  state_nx = WFILL;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Held low while reset is asserted so every output reads zero in reset.
    cmd_ready = wb_rst_n && (state == IDLE);
    wr_ready  = (state == WFILL) || (beat_ack && we && !last_beat);
  end

  // Wishbone master registers, read-return path and completion pulses.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      adr       <= '0;
      dat       <= '0;
      sel       <= '0;
      we        <= 1'b0;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      cti       <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            adr       <= {cmd_adr[31:2], 2'b00};
            we        <= cmd_we;
            remaining <= cmd_len;
            cti       <= (cmd_len == '0) ? CTI_END : CTI_INC;
            sel       <= 4'hF;
            cyc       <= 1'b1;
            stb       <= !cmd_we;
          end
        end
        WFILL: begin
          if (wr_valid) begin
            dat <= wr_data;
            sel <= wr_sel;
            stb <= 1'b1;
          end
        end
        BUS: begin
          if (abort) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            we  <= 1'b0;
            cti <= '0;
            err <= 1'b1;
          end else if (beat_ack) begin
            if (!we) begin
              rd_valid <= 1'b1;
              rd_data  <= wb.wb_dat_i;
              rd_last  <= last_beat;
            end
            if (last_beat) begin
              cyc  <= 1'b0;
              stb  <= 1'b0;
              we   <= 1'b0;
              cti  <= '0;
              done <= 1'b1;
            end else begin
              adr       <= adr + 32'd4;
              remaining <= remaining - LW'(1);
              cti       <= (remaining == LW'(1)) ? CTI_END : CTI_INC;
              if (we) begin
                if (wr_valid) begin
                  dat <= wr_data;
                  sel <= wr_sel;
                end else begin
                  stb <= 1'b0;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // No-response watchdog: counts strobe cycles since the last slave reply.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)
      wdog <= '0;
    else if (!stb || wb.wb_ack_i || wb.wb_err_i || abort)
      wdog <= '0;
    else
      wdog <= wdog + WDW'(1);
  end

endmodule
`default_nettype wire
